// File: rtl/tank_pkg.sv
// Shared constants, FSM/probe types and the probe geometry used by the tank collision block.
package tank_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int ANGLE_MAX = 89;

    typedef enum logic [1:0] {SNAP, QUERY, COMMIT} state_t;
    typedef logic [1:0] probe_idx_t;

    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
    } probe_t;

    // Sign-magnitude trig value times k, scaled back down by 256.
    function automatic logic signed [11:0] scale_off(input logic [8:0] v, input int unsigned k);
        logic [31:0]        p;
        logic signed [11:0] m;
        p = 32'(v[7:0]) * k;
        m = signed'(12'(p >> 8));
        return v[8] ? -m : m;
    endfunction

    function automatic probe_t probe_at(input logic [9:0] x, input logic [9:0] y,
                                        input logic [8:0] s, input logic [8:0] c,
                                        input probe_idx_t idx,
                                        input int unsigned reach, input int unsigned half_w);
        logic signed [11:0] rc, rs, wc, ws, xs, ys;
        probe_t             p;
        rc  = scale_off(c, reach);
        rs  = scale_off(s, reach);
        wc  = scale_off(c, half_w);
        ws  = scale_off(s, half_w);
        xs  = signed'({2'b00, x});
        ys  = signed'({2'b00, y});
        p.x = xs + rc - ws;
        p.y = ys - rs - wc;
        unique case (idx)
            2'd0: begin p.x = xs + rc - ws; p.y = ys - rs - wc; end
            2'd1: begin p.x = xs + rc + ws; p.y = ys - rs + wc; end
            2'd2: begin p.x = xs - rc - ws; p.y = ys + rs - wc; end
            2'd3: begin p.x = xs - rc + ws; p.y = ys + rs + wc; end
        endcase
        return p;
    endfunction

    function automatic logic in_range(input probe_t p);
        return !p.x[11] && (p.x < 12'(SCREEN_W)) && !p.y[11] && (p.y < 12'(SCREEN_H));
    endfunction

endpackage

// File: rtl/tank_collision_trig.sv
// Sin/cos lookup for a 4-degree-per-step heading; 9-bit sign-magnitude, 255 = 1.0.
module tank_collision_trig
    import tank_pkg::*;
(
    input  logic [6:0] angle,
    output logic [8:0] sin_v,
    output logic [8:0] cos_v
);

    // First-quadrant table on even degrees; cos needs the odd multiples of 2.
    function automatic logic [7:0] sin_deg(input logic [8:0] d);
        logic [7:0] t;
        case (d)
            9'd0:  t = 8'd0;   9'd2:  t = 8'd9;   9'd4:  t = 8'd18;  9'd6:  t = 8'd27;
            9'd8:  t = 8'd35;  9'd10: t = 8'd44;  9'd12: t = 8'd53;  9'd14: t = 8'd62;
            9'd16: t = 8'd70;  9'd18: t = 8'd79;  9'd20: t = 8'd87;  9'd22: t = 8'd96;
            9'd24: t = 8'd104; 9'd26: t = 8'd112; 9'd28: t = 8'd120; 9'd30: t = 8'd128;
            9'd32: t = 8'd135; 9'd34: t = 8'd143; 9'd36: t = 8'd150; 9'd38: t = 8'd157;
            9'd40: t = 8'd164; 9'd42: t = 8'd171; 9'd44: t = 8'd177; 9'd46: t = 8'd183;
            9'd48: t = 8'd190; 9'd50: t = 8'd195; 9'd52: t = 8'd201; 9'd54: t = 8'd206;
            9'd56: t = 8'd211; 9'd58: t = 8'd216; 9'd60: t = 8'd221; 9'd62: t = 8'd225;
            9'd64: t = 8'd229; 9'd66: t = 8'd233; 9'd68: t = 8'd236; 9'd70: t = 8'd240;
            9'd72: t = 8'd243; 9'd74: t = 8'd245; 9'd76: t = 8'd247; 9'd78: t = 8'd249;
            9'd80: t = 8'd251; 9'd82: t = 8'd253; 9'd84: t = 8'd254; 9'd86: t = 8'd254;
            9'd88: t = 8'd255;
            default: t = 8'd255;
        endcase
        return t;
    endfunction

    logic [8:0] deg;
    logic [7:0] s_mag, c_mag;
    logic       s_neg, c_neg;

    always_comb begin
        deg = (angle > 7'(ANGLE_MAX)) ? 9'd0 : {angle, 2'b00};
        if (deg <= 9'd90) begin
            s_mag = sin_deg(deg);           s_neg = 1'b0;
            c_mag = sin_deg(9'd90 - deg);   c_neg = 1'b0;
        end else if (deg <= 9'd180) begin
            s_mag = sin_deg(9'd180 - deg);  s_neg = 1'b0;
            c_mag = sin_deg(deg - 9'd90);   c_neg = 1'b1;
        end else if (deg <= 9'd270) begin
            s_mag = sin_deg(deg - 9'd180);  s_neg = 1'b1;
            c_mag = sin_deg(9'd270 - deg);  c_neg = 1'b1;
        end else begin
            s_mag = sin_deg(9'd360 - deg);  s_neg = 1'b1;
            c_mag = sin_deg(deg - 9'd270);  c_neg = 1'b0;
        end
        sin_v = {s_neg && (s_mag != 8'd0), s_mag};
        cos_v = {c_neg && (c_mag != 8'd0), c_mag};
    end

endmodule

// File: rtl/tank_collision.sv
// Sweeps four corner probes around the tank through the wall-map port and registers
// front/back collision flags once per sweep.
module tank_collision
    import tank_pkg::*;
#(
    parameter int unsigned REACH   = 10,
    parameter int unsigned HALF_W  = 6,
    parameter int unsigned TIMEOUT = 7
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [6:0] tank_angle,
    output logic       map_req,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    input  logic       map_ack,
    input  logic       map_wall,
    output logic       front_col,
    output logic       back_col,
    output logic       sweep_done
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    probe_idx_t idx;
    logic [7:0] wait_cnt;
    logic [3:0] hit;
    logic [9:0] x_q, y_q;
    logic [8:0] sin_q, cos_q;
    logic [8:0] sin_live, cos_live;
    probe_t     p_live, p_next, p_load;
    logic       load_ok;

    tank_collision_trig u_trig (
        .angle (tank_angle),
        .sin_v (sin_live),
        .cos_v (cos_live)
    );

    // Probe 0 is loaded straight from the live inputs so the first query starts right after SNAP.
    assign p_live = probe_at(tank_x, tank_y, sin_live, cos_live, 2'd0, REACH, HALF_W);
    assign p_next = probe_at(x_q, y_q, sin_q, cos_q, idx + 2'd1, REACH, HALF_W);

    always_comb begin
        p_load  = (state == SNAP) ? p_live : p_next;
        load_ok = in_range(p_load);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= SNAP;
            idx        <= '0;
            wait_cnt   <= '0;
            hit        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            map_req    <= 1'b0;
            map_x      <= '0;
            map_y      <= '0;
            front_col  <= 1'b0;
            back_col   <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                SNAP: begin
                    x_q      <= tank_x;
                    y_q      <= tank_y;
                    sin_q    <= sin_live;
                    cos_q    <= cos_live;
                    idx      <= '0;
                    wait_cnt <= '0;
                    map_req  <= load_ok;
                    map_x    <= load_ok ? p_load.x[9:0] : '0;
                    map_y    <= load_ok ? p_load.y[9:0] : '0;
                    state    <= QUERY;
                end
                QUERY: begin
                    // Off-screen probe, accepted query or expired wait all retire the probe.
                    if (!map_req || map_ack || wait_cnt == WAIT_LAST) begin
                        hit[idx] <= (map_req && map_ack) ? map_wall : 1'b1;
                        wait_cnt <= '0;
                        if (idx == 2'd3) begin
                            map_req <= 1'b0;
                            map_x   <= '0;
                            map_y   <= '0;
                            state   <= COMMIT;
                        end else begin
                            idx     <= idx + 2'd1;
                            map_req <= load_ok;
                            map_x   <= load_ok ? p_load.x[9:0] : '0;
                            map_y   <= load_ok ? p_load.y[9:0] : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                COMMIT: begin
                    front_col  <= hit[0] | hit[1];
                    back_col   <= hit[2] | hit[3];
                    sweep_done <= 1'b1;
                    hit        <= '0;
                    state      <= SNAP;
                end
                default: state <= SNAP;
            endcase
        end
    end

endmodule

// File: tb/tb_tank_collision.sv
// Directed bench for tank_collision: probe geometry, timeouts, off-screen probes,
// input snapshotting and asynchronous reset.
module tb_tank_collision;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] tank_x = 10'd320;
    logic [9:0] tank_y = 10'd240;
    logic [6:0] tank_angle = 7'd0;
    logic       map_req, map_ack, map_wall;
    logic [9:0] map_x, map_y;
    logic       front_col, back_col, sweep_done;

    logic ack_on = 1'b1;
    logic wall_mode = 1'b0;

    int passed = 0;
    int total = 0;
    int qx[$];
    int qy[$];
    int edges;
    int req_hi;

    always #5 frame_clk = ~frame_clk;

    // Zero-wait responder; the only wall pixel is (329,245) when enabled.
    assign map_ack  = ack_on;
    assign map_wall = wall_mode && (map_x == 10'd329) && (map_y == 10'd245);

    tank_collision dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .tank_x     (tank_x),
        .tank_y     (tank_y),
        .tank_angle (tank_angle),
        .map_req    (map_req),
        .map_x      (map_x),
        .map_y      (map_y),
        .map_ack    (map_ack),
        .map_wall   (map_wall),
        .front_col  (front_col),
        .back_col   (back_col),
        .sweep_done (sweep_done)
    );

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    // Runs until sweep_done, logging accepted queries; optionally rewrites tank_x mid-sweep.
    task automatic run_sweep(input int mod_edge, input logic [9:0] mod_x);
        bit done;
        done = 1'b0;
        qx.delete();
        qy.delete();
        edges  = 0;
        req_hi = 0;
        while (!done && edges < 100) begin
            @(posedge frame_clk);
            #1;
            edges++;
            if (edges == mod_edge) tank_x = mod_x;
            if (map_req) req_hi++;
            if (map_req && map_ack) begin
                qx.push_back(int'(map_x));
                qy.push_back(int'(map_y));
            end
            if (sweep_done) done = 1'b1;
        end
        total++;
        if (!done) $display("FAIL sweep_timeout: got no sweep_done in %0d cycles, required one", edges);
        else passed++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge frame_clk);
        total++;
        if ({map_req, front_col, back_col, sweep_done} !== 4'b0000)
            $display("FAIL reset_flags: got %b, required 0000",
                     {map_req, front_col, back_col, sweep_done});
        else passed++;
        total++;
        if ({map_x, map_y} !== 20'd0)
            $display("FAIL reset_addr: got (%0d,%0d), required (0,0)", map_x, map_y);
        else passed++;
    endtask

    task automatic test_basic();
        int ex[4] = '{329, 329, 311, 311};
        int ey[4] = '{235, 245, 235, 245};
        tank_angle = 7'd0; tank_x = 10'd320; tank_y = 10'd240;
        wall_mode = 1'b1; ack_on = 1'b1;
        do_reset();
        run_sweep(0, 10'd0);
        total++;
        if (edges !== 6) $display("FAIL basic_latency: got %0d cycles, required 6", edges);
        else passed++;
        total++;
        if (req_hi !== 4) $display("FAIL basic_req_cycles: got %0d, required 4", req_hi);
        else passed++;
        total++;
        if (qx.size() !== 4) $display("FAIL basic_query_count: got %0d, required 4", qx.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            int ax, ay;
            ax = (i < qx.size()) ? qx[i] : -1;
            ay = (i < qy.size()) ? qy[i] : -1;
            total++;
            if (ax !== ex[i] || ay !== ey[i])
                $display("FAIL basic_probe%0d: got (%0d,%0d), required (%0d,%0d)",
                         i, ax, ay, ex[i], ey[i]);
            else passed++;
        end
        total++;
        if ({front_col, back_col} !== 2'b10)
            $display("FAIL basic_flags: got %b, required 10", {front_col, back_col});
        else passed++;
        repeat (3) @(posedge frame_clk);
        #1;
        total++;
        if ({front_col, back_col, sweep_done} !== 3'b100)
            $display("FAIL basic_hold: got %b, required 100", {front_col, back_col, sweep_done});
        else passed++;
    endtask

    task automatic test_timeout();
        wall_mode = 1'b0; ack_on = 1'b0;
        do_reset();
        run_sweep(0, 10'd0);
        total++;
        if (req_hi !== 28) $display("FAIL timeout_req_cycles: got %0d, required 28", req_hi);
        else passed++;
        total++;
        if (edges !== 30) $display("FAIL timeout_latency: got %0d cycles, required 30", edges);
        else passed++;
        total++;
        if ({front_col, back_col} !== 2'b11)
            $display("FAIL timeout_flags: got %b, required 11", {front_col, back_col});
        else passed++;
    endtask

    task automatic test_out_of_range();
        int ex[2] = '{14, 14};
        int ey[2] = '{245, 235};
        tank_angle = 7'd45; tank_x = 10'd5; tank_y = 10'd240;
        wall_mode = 1'b0; ack_on = 1'b1;
        do_reset();
        run_sweep(0, 10'd0);
        total++;
        if (edges !== 6 || req_hi !== 2)
            $display("FAIL oor_timing: got %0d cycles/%0d req, required 6/2", edges, req_hi);
        else passed++;
        total++;
        if (qx.size() !== 2) $display("FAIL oor_query_count: got %0d, required 2", qx.size());
        else passed++;
        for (int i = 0; i < 2; i++) begin
            int ax, ay;
            ax = (i < qx.size()) ? qx[i] : -1;
            ay = (i < qy.size()) ? qy[i] : -1;
            total++;
            if (ax !== ex[i] || ay !== ey[i])
                $display("FAIL oor_probe%0d: got (%0d,%0d), required (%0d,%0d)",
                         i + 2, ax, ay, ex[i], ey[i]);
            else passed++;
        end
        total++;
        if ({front_col, back_col} !== 2'b10)
            $display("FAIL oor_flags: got %b, required 10", {front_col, back_col});
        else passed++;
    endtask

    task automatic test_input_ignored();
        int ex[4] = '{329, 329, 311, 311};
        tank_angle = 7'd0; tank_x = 10'd320; tank_y = 10'd240;
        wall_mode = 1'b0; ack_on = 1'b1;
        do_reset();
        run_sweep(2, 10'd100);
        total++;
        if (edges !== 6) $display("FAIL snap_latency: got %0d cycles, required 6", edges);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            int ax;
            ax = (i < qx.size()) ? qx[i] : -1;
            total++;
            if (ax !== ex[i]) $display("FAIL snap_x%0d: got %0d, required %0d", i, ax, ex[i]);
            else passed++;
        end
        total++;
        if ({front_col, back_col} !== 2'b00)
            $display("FAIL snap_flags: got %b, required 00", {front_col, back_col});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ex[4] = '{109, 109, 91, 91};
        int ey[4] = '{235, 245, 235, 245};
        run_sweep(0, 10'd0);
        total++;
        if (edges !== 6) $display("FAIL b2b_latency: got %0d cycles, required 6", edges);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            int ax, ay;
            ax = (i < qx.size()) ? qx[i] : -1;
            ay = (i < qy.size()) ? qy[i] : -1;
            total++;
            if (ax !== ex[i] || ay !== ey[i])
                $display("FAIL b2b_probe%0d: got (%0d,%0d), required (%0d,%0d)",
                         i, ax, ay, ex[i], ey[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        ack_on = 1'b0;
        run_sweep(0, 10'd0);
        total++;
        if ({front_col, back_col} !== 2'b11)
            $display("FAIL midrst_setup: got %b, required 11", {front_col, back_col});
        else passed++;
        repeat (3) @(posedge frame_clk);
        #1;
        total++;
        if (map_req !== 1'b1) $display("FAIL midrst_pending: got map_req=%b, required 1", map_req);
        else passed++;
        #2 Reset = 1'b1;
        #1;
        total++;
        if ({map_req, front_col, back_col, sweep_done} !== 4'b0000)
            $display("FAIL midrst_async: got %b, required 0000",
                     {map_req, front_col, back_col, sweep_done});
        else passed++;
        @(negedge frame_clk);
        Reset = 1'b0;
        @(posedge frame_clk);
        #1;
        total++;
        if (map_req !== 1'b1 || map_x !== 10'd109 || sweep_done !== 1'b0)
            $display("FAIL midrst_resnap: got req=%b x=%0d done=%b, required 1/109/0",
                     map_req, map_x, sweep_done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_out_of_range();
        test_input_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
